// File: rtl/hdmi_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module : hdmi_cfg_pkg
// Brief  : Shared types and constants for the ADV7611 configuration sequencer.
//          The HDMI_CFG_VERIFY_EN macro adds the read-back verify states.
// Rev    : 1.0
// ============================================================================
package hdmi_cfg_pkg;

   localparam int CNT_W = 32;

   localparam int DEV_MSB = 23;
   localparam int DEV_LSB = 17;
   localparam int SUB_MSB = 15;
   localparam int SUB_LSB = 8;
   localparam int DAT_MSB = 7;

   localparam logic [6:0] END_MARKER  = 7'h00;
   localparam logic [7:0] I2C_LEN_ONE = 8'd1;

   typedef enum logic [3:0] {
      ST_RESET_HOLD   = 4'd0,
      ST_RESET_WAIT   = 4'd1,
      ST_FETCH        = 4'd2,
      ST_FETCH_WAIT   = 4'd3,
      ST_ISSUE        = 4'd4,
      ST_ACK_WAIT     = 4'd5,
      ST_XFER_WAIT    = 4'd6,
      ST_NEXT         = 4'd7,
      ST_DONE         = 4'd8
`ifdef HDMI_CFG_VERIFY_EN
      ,
      ST_VERIFY_ISSUE = 4'd9,
      ST_VERIFY_ACK   = 4'd10,
      ST_VERIFY_XFER  = 4'd11,
      ST_COMPARE      = 4'd12
`endif
   } cfg_state_t;

   // Counter value that makes a "count N cycles" state last exactly N cycles.
   function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
      return (cycles <= 0) ? '0 : CNT_W'(cycles - 1);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_cfg_sequencer_delay.sv
`default_nettype none
// ============================================================================
// Module : cfg_delay_counter
// Brief  : Loadable down-counter with zero flag; holds at zero.
// Rev    : 1.0
// ============================================================================
module cfg_delay_counter
   import hdmi_cfg_pkg::*;
#(
   parameter logic [CNT_W-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= INIT_VAL;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/hdmi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module : hdmi_cfg_sequencer
// Brief  : Boot-time ADV7611 register loader driving an I2C master.
//          Define HDMI_CFG_VERIFY_EN to read back and compare every write.
// Rev    : 1.0
// ============================================================================
module hdmi_cfg_sequencer
   import hdmi_cfg_pkg::*;
#(
   parameter int NUM_ENTRIES       = 315,
   parameter int ROM_AW            = 12,
   parameter int RESET_CYCLES      = 500000,
   parameter int POST_RESET_CYCLES = 250000,
   parameter int ACK_TIMEOUT       = 1024
) (
   input  logic              clk_50,
   input  logic              rst_n,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic              i2c_req,
   output logic              i2c_wr,
   output logic [7:0]        i2c_len,
   output logic [6:0]        i2c_dev_addr,
   output logic [7:0]        i2c_sub_addr,
   output logic [7:0]        i2c_tx,
   input  logic [7:0]        i2c_rx,
   input  logic              i2c_busy,
   input  logic              i2c_de,
   output logic              rx_reset_n,
   output logic              done,
   output logic [7:0]        err_count,
   output logic [ROM_AW-1:0] entry_idx
);

   localparam logic [ROM_AW-1:0] c_num_idx = ROM_AW'(NUM_ENTRIES);

   cfg_state_t        r_state,      w_state;
   logic              r_rx_reset_n, w_rx_reset_n;
   logic              r_req,        w_req;
   logic              r_wr,         w_wr;
   logic [6:0]        r_dev,        w_dev;
   logic [7:0]        r_sub,        w_sub;
   logic [7:0]        r_tx,         w_tx;
   logic              r_done,       w_done;
   logic [7:0]        r_err,        w_err;
   logic [ROM_AW-1:0] r_idx,        w_idx;
   logic [ROM_AW-1:0] w_idx_inc;

   logic              w_cnt_load;
   logic [CNT_W-1:0]  w_cnt_val;
   logic              w_cnt_dec;
   logic              w_cnt_zero;

`ifdef HDMI_CFG_VERIFY_EN
   logic              r_de_q;
   logic [7:0]        r_rx_cap, w_rx_cap;
   logic              w_unused;
   assign w_unused = rom_data[16];
`else
   logic              w_unused;
   assign w_unused = ^{rom_data[16], i2c_rx, i2c_de};
`endif

   cfg_delay_counter #(
      .INIT_VAL (cnt_load(RESET_CYCLES))
   ) u_delay (
      .clk        (clk_50),
      .rst_n      (rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   assign w_idx_inc = r_idx + ROM_AW'(1);

   always_comb begin
      w_state      = r_state;
      w_rx_reset_n = r_rx_reset_n;
      w_req        = r_req;
      w_wr         = r_wr;
      w_dev        = r_dev;
      w_sub        = r_sub;
      w_tx         = r_tx;
      w_done       = r_done;
      w_err        = r_err;
      w_idx        = r_idx;
      w_cnt_load   = 1'b0;
      w_cnt_val    = '0;
      w_cnt_dec    = 1'b0;
`ifdef HDMI_CFG_VERIFY_EN
      w_rx_cap     = r_rx_cap;
`endif

      case (r_state)
         ST_RESET_HOLD: begin
            w_rx_reset_n = 1'b0;
            if (w_cnt_zero) begin
               w_rx_reset_n = 1'b1;
               w_cnt_load   = 1'b1;
               w_cnt_val    = cnt_load(POST_RESET_CYCLES);
               w_state      = ST_RESET_WAIT;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end

         ST_RESET_WAIT: begin
            if (w_cnt_zero) begin
               if (NUM_ENTRIES == 0) begin
                  w_done  = 1'b1;
                  w_state = ST_DONE;
               end else begin
                  w_state = ST_FETCH;
               end
            end else begin
               w_cnt_dec = 1'b1;
            end
         end

         // rom_addr follows entry_idx, so the RAM samples it at the end of FETCH.
         ST_FETCH: w_state = ST_FETCH_WAIT;

         ST_FETCH_WAIT: begin
            if (rom_data[DEV_MSB:DEV_LSB] == END_MARKER) begin
               w_done  = 1'b1;
               w_state = ST_DONE;
            end else begin
               w_dev   = rom_data[DEV_MSB:DEV_LSB];
               w_sub   = rom_data[SUB_MSB:SUB_LSB];
               w_tx    = rom_data[DAT_MSB:0];
               w_state = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (!i2c_busy) begin
               w_req      = 1'b1;
               w_wr       = 1'b1;
               w_cnt_load = 1'b1;
               w_cnt_val  = cnt_load(ACK_TIMEOUT);
               w_state    = ST_ACK_WAIT;
            end
         end

         ST_ACK_WAIT: begin
            if (i2c_busy) begin
               w_req   = 1'b0;
               w_state = ST_XFER_WAIT;
            end else if (w_cnt_zero) begin
               w_req   = 1'b0;
               w_err   = sat_inc(r_err);
               w_state = ST_NEXT;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end

         ST_XFER_WAIT: begin
            if (!i2c_busy) begin
`ifdef HDMI_CFG_VERIFY_EN
               w_state = ST_VERIFY_ISSUE;
`else
               w_state = ST_NEXT;
`endif
            end
         end

         ST_NEXT: begin
            w_idx = w_idx_inc;
            if (w_idx_inc == c_num_idx) begin
               w_done  = 1'b1;
               w_state = ST_DONE;
            end else begin
               w_state = ST_FETCH;
            end
         end

         ST_DONE: begin
            if (start) begin
               w_done       = 1'b0;
               w_err        = 8'd0;
               w_idx        = '0;
               w_rx_reset_n = 1'b0;
               w_cnt_load   = 1'b1;
               w_cnt_val    = cnt_load(RESET_CYCLES);
               w_state      = ST_RESET_HOLD;
            end
         end

`ifdef HDMI_CFG_VERIFY_EN
         ST_VERIFY_ISSUE: begin
            if (!i2c_busy) begin
               w_req      = 1'b1;
               w_wr       = 1'b0;
               // Seeded with a value that cannot match, so a read with no data strobe fails.
               w_rx_cap   = ~r_tx;
               w_cnt_load = 1'b1;
               w_cnt_val  = cnt_load(ACK_TIMEOUT);
               w_state    = ST_VERIFY_ACK;
            end
         end

         ST_VERIFY_ACK: begin
            if (i2c_busy) begin
               w_req   = 1'b0;
               w_state = ST_VERIFY_XFER;
            end else if (w_cnt_zero) begin
               w_req   = 1'b0;
               w_wr    = 1'b1;
               w_err   = sat_inc(r_err);
               w_state = ST_NEXT;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end

         ST_VERIFY_XFER: begin
            if (i2c_de && !r_de_q) begin
               w_rx_cap = i2c_rx;
            end
            if (!i2c_busy) begin
               w_state = ST_COMPARE;
            end
         end

         ST_COMPARE: begin
            w_wr = 1'b1;
            if (r_rx_cap != r_tx) begin
               w_err = sat_inc(r_err);
            end
            w_state = ST_NEXT;
         end
`endif

         default: w_state = ST_RESET_HOLD;
      endcase
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_RESET_HOLD;
         r_rx_reset_n <= 1'b0;
         r_req        <= 1'b0;
         r_wr         <= 1'b1;
         r_dev        <= 7'd0;
         r_sub        <= 8'd0;
         r_tx         <= 8'd0;
         r_done       <= 1'b0;
         r_err        <= 8'd0;
         r_idx        <= '0;
      end else begin
         r_state      <= w_state;
         r_rx_reset_n <= w_rx_reset_n;
         r_req        <= w_req;
         r_wr         <= w_wr;
         r_dev        <= w_dev;
         r_sub        <= w_sub;
         r_tx         <= w_tx;
         r_done       <= w_done;
         r_err        <= w_err;
         r_idx        <= w_idx;
      end
   end

`ifdef HDMI_CFG_VERIFY_EN
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_de_q   <= 1'b0;
         r_rx_cap <= 8'd0;
      end else begin
         r_de_q   <= i2c_de;
         r_rx_cap <= w_rx_cap;
      end
   end
`endif

   assign rom_addr     = r_idx;
   assign entry_idx    = r_idx;
   assign i2c_req      = r_req;
   assign i2c_wr       = r_wr;
   assign i2c_len      = I2C_LEN_ONE;
   assign i2c_dev_addr = r_dev;
   assign i2c_sub_addr = r_sub;
   assign i2c_tx       = r_tx;
   assign rx_reset_n   = r_rx_reset_n;
   assign done         = r_done;
   assign err_count    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_cfg_sequencer.sv
`default_nettype none
// Bench for hdmi_cfg_sequencer: behavioural RAM and I2C slave, transfer scoreboard.
module tb_hdmi_cfg_sequencer;

   localparam int NE = 4, AW = 4, RC = 10, PC = 5, AT = 16, HOLD = 20, BUSY_DLY = 3;

   typedef struct packed {
      logic [6:0] dev;
      logic [7:0] sub;
      logic [7:0] tx;
      logic       wr;
   } xfer_t;

   logic clk_50 = 1'b0;
   always #10 clk_50 = ~clk_50;

   logic          rst_n, start;
   logic [AW-1:0] rom_addr, entry_idx;
   logic [23:0]   rom_data;
   logic          i2c_req, i2c_wr, i2c_busy, i2c_de, rx_reset_n, done;
   logic [7:0]    i2c_len, i2c_sub_addr, i2c_tx, i2c_rx, err_count;
   logic [6:0]    i2c_dev_addr;

   // Second instance with an empty table
   logic [AW-1:0] z_rom_addr, z_entry_idx;
   logic [23:0]   z_rom_data = 24'h98F480;
   logic          z_req, z_wr, z_rx_reset_n, z_done;
   logic [7:0]    z_len, z_sub, z_tx, z_err;
   logic [6:0]    z_dev;
   logic          z_busy = 1'b0, z_de = 1'b0;
   logic [7:0]    z_rx = 8'd0;
   int            z_req_cnt = 0;

   logic [23:0] rom [16];
   xfer_t       log_q[$];
   xfer_t       exp_q[$];
   int          n_checks = 0, n_fail = 0;
   logic        mute_en = 1'b0;
   int          mute_idx = 0;

   hdmi_cfg_sequencer #(
      .NUM_ENTRIES(NE), .ROM_AW(AW), .RESET_CYCLES(RC),
      .POST_RESET_CYCLES(PC), .ACK_TIMEOUT(AT)
   ) dut (
      .clk_50(clk_50), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
      .rom_data(rom_data), .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_len(i2c_len),
      .i2c_dev_addr(i2c_dev_addr), .i2c_sub_addr(i2c_sub_addr), .i2c_tx(i2c_tx),
      .i2c_rx(i2c_rx), .i2c_busy(i2c_busy), .i2c_de(i2c_de), .rx_reset_n(rx_reset_n),
      .done(done), .err_count(err_count), .entry_idx(entry_idx)
   );

   hdmi_cfg_sequencer #(
      .NUM_ENTRIES(0), .ROM_AW(AW), .RESET_CYCLES(RC),
      .POST_RESET_CYCLES(PC), .ACK_TIMEOUT(AT)
   ) dut_z (
      .clk_50(clk_50), .rst_n(rst_n), .start(1'b0), .rom_addr(z_rom_addr),
      .rom_data(z_rom_data), .i2c_req(z_req), .i2c_wr(z_wr), .i2c_len(z_len),
      .i2c_dev_addr(z_dev), .i2c_sub_addr(z_sub), .i2c_tx(z_tx),
      .i2c_rx(z_rx), .i2c_busy(z_busy), .i2c_de(z_de), .rx_reset_n(z_rx_reset_n),
      .done(z_done), .err_count(z_err), .entry_idx(z_entry_idx)
   );

   // Synchronous config RAM: one cycle read latency
   always @(posedge clk_50) rom_data <= rom[rom_addr];

   initial forever begin
      @(negedge clk_50);
      if (z_req) z_req_cnt++;
   end

   // I2C slave model: busy BUSY_DLY cycles after a request, held HOLD cycles,
   // a data strobe near the end; reads return the last written byte, except 8'h80 reads as 8'h00.
   initial begin
      logic       prev_req;
      int         phase, cnt;
      logic [7:0] last_tx;
      i2c_busy = 1'b0; i2c_de = 1'b0; i2c_rx = 8'd0;
      prev_req = 1'b0; phase = 0; cnt = 0; last_tx = 8'd0;
      forever begin
         @(negedge clk_50);
         if (!rst_n) begin
            i2c_busy = 1'b0; i2c_de = 1'b0; phase = 0; prev_req = 1'b0;
         end else begin
            if (i2c_req && !prev_req) begin
               log_q.push_back(xfer_t'({i2c_dev_addr, i2c_sub_addr, i2c_tx, i2c_wr}));
               if (i2c_wr) last_tx = i2c_tx;
               if (!(mute_en && i2c_wr && (int'(entry_idx) == mute_idx))) begin
                  phase = 1; cnt = BUSY_DLY;
               end
            end
            prev_req = i2c_req;
            case (phase)
               1: begin
                  cnt--;
                  if (cnt == 0) begin i2c_busy = 1'b1; cnt = HOLD; phase = 2; end
               end
               2: begin
                  cnt--;
                  if (cnt == 2) begin
                     i2c_de = 1'b1;
                     i2c_rx = (last_tx == 8'h80) ? 8'h00 : last_tx;
                  end else if (cnt == 1) begin
                     i2c_de = 1'b0;
                  end else if (cnt == 0) begin
                     i2c_busy = 1'b0; phase = 0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_table();
      for (int i = 0; i < 16; i++)
         rom[i] = {7'($urandom_range(1, 127)), 1'b0, 8'($urandom), 8'($urandom)};
      rom[0] = 24'h98F480;
   endtask

   task automatic restart();
      log_q.delete();
      @(negedge clk_50); start = 1'b1;
      @(negedge clk_50); start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 20000) begin @(negedge clk_50); n++; end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
   endtask

   // Reference: walk the table by its rules and list the bus transfers it implies.
   task automatic check_run(input string tag);
      int exp_err = 0, last = NE, m;
      exp_q.delete();
      for (int i = 0; i < NE; i++) begin
         if (rom[i][23:17] == 7'h00) begin last = i; break; end
         exp_q.push_back(xfer_t'({rom[i][23:17], rom[i][15:8], rom[i][7:0], 1'b1}));
         if (mute_en && i == mute_idx) exp_err++;
`ifdef HDMI_CFG_VERIFY_EN
         else begin
            exp_q.push_back(xfer_t'({rom[i][23:17], rom[i][15:8], rom[i][7:0], 1'b0}));
            if (rom[i][7:0] == 8'h80) exp_err++;
         end
`endif
      end
      check({tag, "_nxfer"}, log_q.size(), exp_q.size());
      m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < m; i++)
         check($sformatf("%s_xfer%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
      check({tag, "_err"}, 32'(err_count), (exp_err > 255) ? 32'd255 : 32'(exp_err));
      check({tag, "_idx"}, 32'(entry_idx), 32'(last));
      check({tag, "_req_idle"}, {31'd0, i2c_req}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_reset_n"}, {31'd0, rx_reset_n}, 32'd0);
      check({tag, "_req"}, {31'd0, i2c_req}, 32'd0);
      check({tag, "_wr"}, {31'd0, i2c_wr}, 32'd1);
      check({tag, "_len"}, 32'(i2c_len), 32'd1);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_err"}, 32'(err_count), 32'd0);
      check({tag, "_idx"}, 32'(entry_idx), 32'd0);
      check({tag, "_addr"}, 32'(rom_addr), 32'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0;
      fill_table();
      repeat (3) @(negedge clk_50);
      check_reset_outputs("rst");
      check("rst_dev", 32'(i2c_dev_addr), 32'd0);
      check("rst_sub", 32'(i2c_sub_addr), 32'd0);
      check("rst_tx", 32'(i2c_tx), 32'd0);

      // Receiver reset pulse length and the gap to the first request
      rst_n = 1'b1;
      n = 0;
      while (!rx_reset_n && n < 1000) begin @(posedge clk_50); #1; n++; end
      check("rx_reset_low_cycles", n, RC);
      n = 0;
      while (!i2c_req && n < 1000) begin @(posedge clk_50); #1; n++; end
      check("first_req_gap", {31'd0, (n >= PC && n <= PC + 4)}, 32'd1);
      check("first_dev", 32'(i2c_dev_addr), 32'h4C);
      check("first_sub", 32'(i2c_sub_addr), 32'hF4);
      check("first_tx", 32'(i2c_tx), 32'h80);
      check("first_wr", {31'd0, i2c_wr}, 32'd1);

      // start outside DONE must be ignored
      @(negedge clk_50); start = 1'b1;
      @(negedge clk_50); start = 1'b0;
      wait_done("basic");
      check_run("basic");

      check("empty_done", {31'd0, z_done}, 32'd1);
      check("empty_no_req", z_req_cnt, 0);
      check("empty_idx", 32'(z_entry_idx), 32'd0);

      fill_table();
      restart();
      wait_done("rand");
      check_run("rand");

      // End-of-table marker at entry 2
      fill_table();
      rom[2][23:17] = 7'h00;
      restart();
      wait_done("marker");
      check_run("marker");

      // Entry 1 never acknowledged
      fill_table();
      mute_en = 1'b1; mute_idx = 1;
      restart();
      n = 0;
      while (!(entry_idx == AW'(1) && i2c_req) && n < 5000) begin @(negedge clk_50); n++; end
      check("mute_req_seen", {31'd0, i2c_req}, 32'd1);
      n = 0;
      while (i2c_req && n < 100) begin @(negedge clk_50); n++; end
      check("mute_req_high_cycles", n, AT);
      wait_done("mute");
      check_run("mute");
      mute_en = 1'b0;

      // Reset asserted during the data phase of entry 3
      fill_table();
      restart();
      n = 0;
      while (!(entry_idx == AW'(3) && i2c_busy && !i2c_req) && n < 5000) begin
         @(negedge clk_50); n++;
      end
      check("midrst_reached", {31'd0, i2c_busy}, 32'd1);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      repeat (2) @(negedge clk_50);
      log_q.delete();
      rst_n = 1'b1;
      wait_done("after_rst");
      check_run("after_rst");

      restart();
      wait_done("repeat");
      check_run("repeat");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
